cu_cond_sequencer: RTL and testbench
====================================

CU_COND_SEQUENCER -- requirements
Module: cu_cond_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter FLUSH_CYCLES SHALL default to 2 and is the number of flush cycles after a taken branch; legal range is 1..15.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 instr_valid  in  1  decoded instruction present this cycle.
REQ-006 instr_ready  out  1  sequencer can accept this cycle; an instruction is accepted when instr_valid && instr_ready.
REQ-007 cond  in  4  condition field of the presented instruction.
REQ-008 pcs_in, reg_write_in, mem_write_in  in  1 each  ungated control requests from decode.
REQ-009 flag_we_a, flag_we_b  in  1 each  instruction requests a write of flag set A or B.
REQ-010 alu_flags_a, alu_flags_b  in  2 each  new flag values from the ALU.
REQ-011 pc_src, reg_write, mem_write  out  1 each  gated controls, registered.
REQ-012 cond_ex  out  1  registered condition result of the last accepted instruction.
REQ-013 flush  out  1  pipeline flush request.
REQ-014 flags_a_q, flags_b_q  out  2 each  architectural flag registers.
REQ-015 exec_count, squash_count  out  16 each  statistics counters (see Configuration).

Function
REQ-016 The combinational condition SHALL be: 0000 -> flags_a_q[1]; 0001 -> ~flags_a_q[1]; 0010 -> flags_b_q[1]; 0100 -> flags_a_q[0]; 1111 -> 1; all other codes -> 0.
REQ-017 Evaluation SHALL use flag register values from before the accepting edge; an instruction never sees its own flag write.
REQ-018 The FSM SHALL have two states: RUN (instr_ready=1, flush=0) and FLUSH (instr_ready=0, flush=1).
REQ-019 On accept in RUN, on the next edge pc_src<=pcs_in&c, reg_write<=reg_write_in&c, mem_write<=mem_write_in&c, cond_ex<=c, where c is the REQ-016 result; the latency is one cycle.
REQ-020 In any cycle without an accept, pc_src, reg_write, mem_write and cond_ex SHALL be 0 on the next edge, so each output is a single-cycle pulse per instruction.
REQ-021 On accept with c=1 and flag_we_a=1, flags_a_q SHALL load alu_flags_a at that edge; flag set B likewise; with c=0 both flag registers SHALL hold.
REQ-022 On accept with pcs_in&c=1, the FSM SHALL enter FLUSH at that edge and load a 4-bit counter with FLUSH_CYCLES.
REQ-023 In FLUSH the counter SHALL decrement each edge, and the FSM SHALL return to RUN on the edge where the counter equals 1, giving exactly FLUSH_CYCLES cycles with flush=1.
REQ-024 While in FLUSH, instr_valid SHALL be ignored: no flag, counter or output update occurs.
REQ-025 Back-to-back accepts in RUN SHALL be allowed every cycle, with no bubble.

Reset
REQ-026 While rst=1 at an edge, the block SHALL enter RUN, clear the flush counter, and set all outputs, flags_a_q, flags_b_q, exec_count and squash_count to 0; rst has priority over any accept.
REQ-027 A reset asserted mid-FLUSH SHALL abort the flush, and instr_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro COND_STATS_EN SHALL control the statistics counters.
REQ-029 With COND_STATS_EN defined, each accept SHALL increment exec_count if c=1 and squash_count if c=0; both counters wrap from 16'hFFFF to 16'h0000.
REQ-030 Without COND_STATS_EN, the ports SHALL remain present, be tied to 0, and no counter flops SHALL be inferred.

Verification
REQ-031 Reset, then accept cond=1111, reg_write_in=1, flag_we_a=1, alu_flags_a=10 -> next cycle reg_write=1, cond_ex=1, flags_a_q=10.
REQ-032 With flags_a_q=10, accept cond=0001 with mem_write_in=1 -> mem_write=0, cond_ex=0, flags hold; then accept cond=0000 with mem_write_in=1 -> mem_write=1.
REQ-033 Accept a taken branch (cond=1111, pcs_in=1) with FLUSH_CYCLES=2 -> pc_src pulses one cycle, flush=1 and instr_ready=0 for exactly 2 cycles, and valid instructions during those cycles have no effect.
REQ-034 Accept cond=0000 with flag_we_a=1, alu_flags_a=10 while flags_a_q=00 -> cond_ex=0 and flags_a_q stays 00, because evaluation uses old flags and the write is squashed.
REQ-035 Assert rst during the first FLUSH cycle -> flush=0 and instr_ready=1 the cycle after rst deasserts, with all flags 0.
REQ-036 With COND_STATS_EN, preload to 16'hFFFF via 65535 executed accepts, then one more -> exec_count=0; without the macro, exec_count and squash_count stay 0 throughout.

Source files
------------

// File: rtl/cu_cond_sequencer.sv
// cu_cond_sequencer: conditional-execution sequencer.
// Evaluates the 4-bit condition of each accepted instruction against the
// architectural flag registers, gates the decode control requests with the
// result, and holds off new instructions for FLUSH_CYCLES cycles after a
// taken branch.
// Optional feature: define COND_STATS_EN to build the executed/squashed
// statistics counters; otherwise both count ports are tied to zero.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | accepting instructions, instr_ready=1, flush=0
// FLUSH  | draining after a taken branch, instr_ready=0, flush=1
module cu_cond_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  cond,
    input  logic        pcs_in,
    input  logic        reg_write_in,
    input  logic        mem_write_in,
    input  logic        flag_we_a,
    input  logic        flag_we_b,
    input  logic [1:0]  alu_flags_a,
    input  logic [1:0]  alu_flags_b,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_write,
    output logic        cond_ex,
    output logic        flush,
    output logic [1:0]  flags_a_q,
    output logic [1:0]  flags_b_q,
    output logic [15:0] exec_count,
    output logic [15:0] squash_count
);

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;
    logic       c;
    logic       taken;

    assign accept = instr_valid && instr_ready;
    assign taken  = accept && pcs_in && c;

    // Condition decode against the flags as they stand before this edge.
    always_comb begin
        c = 1'b0;
        case (cond)
            4'b0000: c = flags_a_q[1];
            4'b0001: c = ~flags_a_q[1];
            4'b0010: c = flags_b_q[1];
            4'b0100: c = flags_a_q[0];
            4'b1111: c = 1'b1;
            default: c = 1'b0;
        endcase
    end

    // State register and flush down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a taken branch arms the counter; leave FLUSH at terminal count 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (taken) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 4'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        instr_ready = 1'b0;
        flush       = 1'b0;
        case (state_q)
            ST_RUN:   instr_ready = 1'b1;
            ST_FLUSH: flush       = 1'b1;
            default:  instr_ready = 1'b0;
        endcase
    end

    // Gated controls pulse for one cycle per accepted instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_src    <= 1'b0;
            reg_write <= 1'b0;
            mem_write <= 1'b0;
            cond_ex   <= 1'b0;
        end else begin
            pc_src    <= taken;
            reg_write <= accept && reg_write_in && c;
            mem_write <= accept && mem_write_in && c;
            cond_ex   <= accept && c;
        end
    end

    // Flag writes are squashed along with the instruction when c=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_a_q <= 2'b00;
            flags_b_q <= 2'b00;
        end else begin
            if (accept && c && flag_we_a) flags_a_q <= alu_flags_a;
            if (accept && c && flag_we_b) flags_b_q <= alu_flags_b;
        end
    end

`ifdef COND_STATS_EN
    // Executed/squashed counters, free-running with natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            exec_count   <= 16'd0;
            squash_count <= 16'd0;
        end else if (accept) begin
            if (c) exec_count   <= exec_count + 16'd1;
            else   squash_count <= squash_count + 16'd1;
        end
    end
`else
    assign exec_count   = 16'd0;
    assign squash_count = 16'd0;
`endif

endmodule

// File: tb/tb_cu_cond_sequencer.sv
// Self-checking bench for cu_cond_sequencer: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_cu_cond_sequencer;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  cond;
    logic        pcs_in, reg_write_in, mem_write_in;
    logic        flag_we_a, flag_we_b;
    logic [1:0]  alu_flags_a, alu_flags_b;
    logic        pc_src, reg_write, mem_write, cond_ex, flush;
    logic [1:0]  flags_a_q, flags_b_q;
    logic [15:0] exec_count, squash_count;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int        m_busy;
    bit [1:0]  m_fa, m_fb;
    bit        m_pc, m_rw, m_mw, m_cx;
    bit [15:0] m_exec, m_squash;

    always #5 clk = ~clk;

    cu_cond_sequencer #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .cond(cond), .pcs_in(pcs_in), .reg_write_in(reg_write_in),
        .mem_write_in(mem_write_in), .flag_we_a(flag_we_a), .flag_we_b(flag_we_b),
        .alu_flags_a(alu_flags_a), .alu_flags_b(alu_flags_b),
        .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write),
        .cond_ex(cond_ex), .flush(flush),
        .flags_a_q(flags_a_q), .flags_b_q(flags_b_q),
        .exec_count(exec_count), .squash_count(squash_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic bit cond_true(input bit [3:0] cd, input bit [1:0] fa, input bit [1:0] fb);
        if (cd == 4'd0)  return fa[1];
        if (cd == 4'd1)  return !fa[1];
        if (cd == 4'd2)  return fb[1];
        if (cd == 4'd4)  return fa[0];
        if (cd == 4'd15) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        instr_valid = 0; cond = 4'd0; pcs_in = 0; reg_write_in = 0; mem_write_in = 0;
        flag_we_a = 0; flag_we_b = 0; alu_flags_a = 2'b00; alu_flags_b = 2'b00;
    endtask

    // One clock: check handshake, advance model at the edge, check registered outputs.
    task automatic tick();
        bit c;
        chk("instr_ready", instr_ready, (m_busy == 0));
        chk("flush", flush, (m_busy > 0));
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_fa = 0; m_fb = 0;
            m_pc = 0; m_rw = 0; m_mw = 0; m_cx = 0;
            m_exec = 0; m_squash = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            m_pc = 0; m_rw = 0; m_mw = 0; m_cx = 0;
        end else if (instr_valid) begin
            c = cond_true(cond, m_fa, m_fb);
            m_pc = pcs_in & c; m_rw = reg_write_in & c; m_mw = mem_write_in & c; m_cx = c;
            if (c && flag_we_a) m_fa = alu_flags_a;
            if (c && flag_we_b) m_fb = alu_flags_b;
            if (c) m_exec++; else m_squash++;
            if (pcs_in && c) m_busy = FC;
        end else begin
            m_pc = 0; m_rw = 0; m_mw = 0; m_cx = 0;
        end
        #1;
        chk("pc_src", pc_src, m_pc);
        chk("reg_write", reg_write, m_rw);
        chk("mem_write", mem_write, m_mw);
        chk("cond_ex", cond_ex, m_cx);
        chk("flags_a_q", flags_a_q, m_fa);
        chk("flags_b_q", flags_b_q, m_fb);
`ifdef COND_STATS_EN
        chk("exec_count", exec_count, m_exec);
        chk("squash_count", squash_count, m_squash);
`else
        chk("exec_count", exec_count, 16'd0);
        chk("squash_count", squash_count, 16'd0);
`endif
        @(negedge clk);
    endtask

    initial begin
        m_busy = 0; m_fa = 0; m_fb = 0; m_pc = 0; m_rw = 0; m_mw = 0; m_cx = 0;
        m_exec = 0; m_squash = 0;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        tick(); tick();
        rst = 0;
        chk("rst_ready", instr_ready, 1);
        chk("rst_flags_a", flags_a_q, 0);

        // unconditional execute with flag write
        instr_valid = 1; cond = 4'b1111; reg_write_in = 1; flag_we_a = 1; alu_flags_a = 2'b10;
        tick();
        chk("d1_reg_write", reg_write, 1);
        chk("d1_cond_ex", cond_ex, 1);
        chk("d1_flags_a", flags_a_q, 2'b10);

        // NE-like fails, EQ-like passes
        idle_inputs(); instr_valid = 1; cond = 4'b0001; mem_write_in = 1;
        flag_we_a = 1; alu_flags_a = 2'b01;
        tick();
        chk("d2_mem_write", mem_write, 0);
        chk("d2_cond_ex", cond_ex, 0);
        chk("d2_flags_hold", flags_a_q, 2'b10);
        idle_inputs(); instr_valid = 1; cond = 4'b0000; mem_write_in = 1;
        tick();
        chk("d2b_mem_write", mem_write, 1);

        // taken branch, valid instructions during flush are ignored
        idle_inputs(); instr_valid = 1; cond = 4'b1111; pcs_in = 1;
        tick();
        chk("d3_pc_src", pc_src, 1);
        chk("d3_flush1", flush, 1);
        idle_inputs(); instr_valid = 1; cond = 4'b1111; reg_write_in = 1;
        flag_we_b = 1; alu_flags_b = 2'b11;
        tick();
        chk("d3_pc_pulse", pc_src, 0);
        chk("d3_flush2", flush, 1);
        chk("d3_ignored_rw", reg_write, 0);
        tick();
        chk("d3_ignored_fb", flags_b_q, 2'b00);
        chk("d3_ready_back", instr_ready, 1);
        idle_inputs(); tick();

        // old-flag evaluation: reset flags then squash own write
        rst = 1; tick(); rst = 0;
        instr_valid = 1; cond = 4'b0000; flag_we_a = 1; alu_flags_a = 2'b10;
        tick();
        chk("d4_cond_ex", cond_ex, 0);
        chk("d4_flags_a", flags_a_q, 2'b00);

        // reset in the first flush cycle
        idle_inputs(); instr_valid = 1; cond = 4'b1111; pcs_in = 1;
        flag_we_a = 1; alu_flags_a = 2'b11;
        tick();
        chk("d5_in_flush", flush, 1);
        idle_inputs(); rst = 1; tick(); rst = 0;
        chk("d5_ready", instr_ready, 1);
        chk("d5_flush", flush, 0);
        chk("d5_flags_a", flags_a_q, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            instr_valid  = ($urandom_range(0, 3) != 0);
            cond         = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) :
                           (($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 2) == 2 ? 4 : $urandom_range(0, 2)));
            pcs_in       = ($urandom_range(0, 5) == 0);
            reg_write_in = 1'($urandom);
            mem_write_in = 1'($urandom);
            flag_we_a    = 1'($urandom);
            flag_we_b    = 1'($urandom);
            alu_flags_a  = 2'($urandom);
            alu_flags_b  = 2'($urandom);
            tick();
        end
        rst = 0;
        idle_inputs();
        tick();

`ifdef COND_STATS_EN
        // counter wrap
        rst = 1; tick(); rst = 0;
        instr_valid = 1; cond = 4'b1111;
        for (int i = 0; i < 65535; i++) tick();
        chk("wrap_pre", exec_count, 16'hFFFF);
        tick();
        chk("wrap_post", exec_count, 16'h0000);
        idle_inputs(); tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
